ram_bank: RTL and testbench

- Parametrised successor to the fixed 8-word RAM.
- Generic WIDTH × DEPTH word memory with the same write and read model: synchronous write on load, combinational read at address.
- Adds an asynchronous active-high reset and a hardware clear sequencer that zero-fills every word, with a busy status output.
- Used as the general data/program memory building block under the CPU datapath.

---
 rtl/ram_bank_pkg.sv | 13 +
 rtl/ram_clear_seq.sv | 54 +++++
 rtl/ram_bank.sv | 77 +++++++
 tb/tb_ram_bank.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bank_pkg.sv
// Shared types and defaults for the ram_bank memory slice.
// Holds the clear-sequencer state encoding and default geometry.
package ram_bank_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Zero-fill sequencer for ram_bank: walks every word once after
// reset or a clear request, owning the array while busy.
module ram_clear_seq
  import ram_bank_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        r_state;
  logic [AW-1:0] r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      unique case (r_state)
        ST_CLEAR: begin
          if (r_ptr == LAST) begin
            r_ptr   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_ptr <= r_ptr + AW'(1);
          end
        end
        ST_IDLE: begin
          if (clear) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  assign busy     = (r_state == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = r_ptr;

endmodule

// File: rtl/ram_bank.sv
// WIDTH x DEPTH RAM: sync write, combinational read, hardware clear.
// Define RAM_PARITY_EN to add a per-word even-parity bit and parity_err.
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    address,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy
`ifdef RAM_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_busy;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_addr;
  logic             w_in_range;
  logic             w_user_we;
  logic [WIDTH-1:0] w_rd;

  ram_clear_seq #(
    .DEPTH(DEPTH)
  ) u_seq (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .busy    (w_busy),
    .clr_we  (w_clr_we),
    .clr_addr(w_clr_addr)
  );

  assign w_in_range = ({1'b0, address} < DEPTH_W);
  // clear in the same IDLE cycle as load takes priority
  assign w_user_we  = load && !clear && w_in_range;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_user_we) begin
      r_mem[address] <= in;
    end
  end

  assign w_rd = r_mem[address];
  assign out  = (!w_busy && w_in_range) ? w_rd : '0;
  assign busy = w_busy;

`ifdef RAM_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_par[w_clr_addr] <= 1'b0;
    end else if (w_user_we) begin
      r_par[address] <= ^in;
    end
  end

  assign parity_err = !w_busy && w_in_range &&
                      ((^w_rd) != r_par[address]);
`endif

endmodule

// File: tb/tb_ram_bank.sv
// Bench for ram_bank: DEPTH=8 and DEPTH=5 instances checked every
// cycle against an array model, plus directed literal checks.
module tb_ram_bank;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst  [2];
  logic [2:0]   addr [2];
  logic [W-1:0] din  [2];
  logic         ld   [2];
  logic         cl   [2];

  wire [W-1:0] o0, o1;
  wire         b0, b1;
`ifdef RAM_PARITY_EN
  wire         p0, p1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int           dep [2] = '{8, 5};
  logic [W-1:0] m   [2][8];
  int           rem [2];
  bit           en = 1'b0;

  ram_bank #(.WIDTH(16), .DEPTH(8)) dut8 (
    .clk(clk), .reset(rst[0]), .address(addr[0]),
    .in(din[0]), .load(ld[0]), .clear(cl[0]),
    .out(o0), .busy(b0)
`ifdef RAM_PARITY_EN
    , .parity_err(p0)
`endif
  );

  ram_bank #(.WIDTH(16), .DEPTH(5)) dut5 (
    .clk(clk), .reset(rst[1]), .address(addr[1]),
    .in(din[1]), .load(ld[1]), .clear(cl[1]),
    .out(o1), .busy(b1)
`ifdef RAM_PARITY_EN
    , .parity_err(p1)
`endif
  );

  function automatic logic [W-1:0] out_of(int k);
    return (k == 0) ? o0 : o1;
  endfunction

  function automatic logic busy_of(int k);
    return (k == 0) ? b0 : b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: a clear takes DEPTH edges, after which every word is zero.
  task automatic step(int k);
    if (rst[k]) begin
      rem[k] = dep[k];
    end else if (rem[k] > 0) begin
      rem[k]--;
      if (rem[k] == 0)
        for (int i = 0; i < 8; i++) m[k][i] = '0;
    end else if (cl[k]) begin
      rem[k] = dep[k];
    end else if (ld[k] && int'(addr[k]) < dep[k]) begin
      m[k][addr[k]] = din[k];
    end
  endtask

  always @(posedge clk or posedge rst[0]) step(0);
  always @(posedge clk or posedge rst[1]) step(1);

  always @(negedge clk) begin
    if (en) begin
      for (int k = 0; k < 2; k++) begin
        logic         eb;
        logic [W-1:0] eo;
        eb = (rem[k] > 0);
        eo = (eb || int'(addr[k]) >= dep[k]) ? '0 : m[k][addr[k]];
        chk((k == 0) ? "busy8" : "busy5", busy_of(k), eb);
        chk((k == 0) ? "out8" : "out5", out_of(k), eo);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(int k, logic [2:0] a, logic [W-1:0] d);
    addr[k] = a;
    din[k]  = d;
    ld[k]   = 1'b1;
    tick();
    ld[k]   = 1'b0;
  endtask

  task automatic rd(int k, logic [2:0] a, logic [W-1:0] e, string nm);
    addr[k] = a;
    ld[k]   = 1'b0;
    #1;
    chk(nm, out_of(k), e);
    tick();
  endtask

  task automatic count_busy(int k, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy_of(k)) break;
      n++;
      tick();
    end
  endtask

  int n;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; addr[k] = '0; din[k] = '0;
      ld[k] = 1'b0;  cl[k] = 1'b0; rem[k] = dep[k];
      for (int i = 0; i < 8; i++) m[k][i] = '0;
    end
    #1;
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    #1;
    en = 1'b1;
    #1;
    chk("rst_busy", b0, 1'b1);
    chk("rst_out", o0, 16'h0);
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    count_busy(0, n);
    chk("rst_len8", n, 8);
    for (int a = 0; a < 8; a++) rd(0, 3'(a), 16'h0, "rd_zero");

    wr(0, 3'd0, 16'hBEEF);
    wr(0, 3'd3, 16'h1234);
    wr(0, 3'd7, 16'h0001);
    rd(0, 3'd0, 16'hBEEF, "rd_a0");
    rd(0, 3'd3, 16'h1234, "rd_a3");
    rd(0, 3'd7, 16'h0001, "rd_a7");
    rd(0, 3'd5, 16'h0000, "rd_a5");
    addr[0] = 3'd7;
    din[0]  = 16'hFFFF;
    tick();
    rd(0, 3'd7, 16'h0001, "noload");

    cl[0] = 1'b1;
    tick();
    cl[0] = 1'b0;
    chk("clr_busy", b0, 1'b1);
    repeat (5) tick();
    wr(0, 3'd2, 16'hAAAA);
    count_busy(0, n);
    chk("clr_tail", n, 2);
    for (int a = 0; a < 8; a++) rd(0, 3'(a), 16'h0, "clr_zero");

    cl[0] = 1'b1;
    tick();
    cl[0] = 1'b0;
    repeat (4) tick();
    rst[0] = 1'b1;
    tick();
    chk("rstmid_busy", b0, 1'b1);
    rst[0] = 1'b0;
    count_busy(0, n);
    chk("rstmid_len", n, 8);

    wr(0, 3'd1, 16'h1111);
    addr[0] = 3'd1;
    din[0]  = 16'h5555;
    ld[0]   = 1'b1;
    cl[0]   = 1'b1;
    tick();
    ld[0]   = 1'b0;
    cl[0]   = 1'b0;
    count_busy(0, n);
    chk("clrld_len", n, 8);
    rd(0, 3'd1, 16'h0, "clrld_rd");

    wr(1, 3'd6, 16'h00FF);
    rd(1, 3'd6, 16'h0, "oor_rd");
    for (int a = 0; a < 5; a++) rd(1, 3'(a), 16'h0, "oor_keep");
    wr(1, 3'd4, 16'h1357);
    rd(1, 3'd4, 16'h1357, "d5_a4");

`ifdef RAM_PARITY_EN
    wr(1, 3'd3, 16'h0007);
    addr[1] = 3'd3;
    #1;
    chk("par_ok", p1, 1'b0);
    dut5.r_par[3] = ~dut5.r_par[3];
    #1;
    chk("par_err3", p1, 1'b1);
    addr[1] = 3'd2;
    #1;
    chk("par_err2", p1, 1'b0);
    tick();
    cl[1] = 1'b1;
    tick();
    cl[1] = 1'b0;
    count_busy(1, n);
    chk("par_clr_len", n, 5);
`endif

    repeat (400) begin
      for (int k = 0; k < 2; k++) begin
        rst[k]  = ($urandom_range(0, 99) == 0);
        cl[k]   = ($urandom_range(0, 19) == 0);
        ld[k]   = 1'($urandom_range(0, 1));
        addr[k] = 3'($urandom_range(0, 7));
        din[k]  = W'($urandom);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; ld[k] = 1'b0; cl[k] = 1'b0;
    end
    repeat (12) tick();
    en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
